// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_SHIFT  = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  localparam int   FRAME_DATA_BITS = 8;
  localparam logic PS2_IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/ps2_rx_frontend_byte_fifo.sv
// Byte FIFO with extra pointer MSB for full/empty; head byte reads as zero when empty.
module byte_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

  logic [7:0]          r_mem [DEPTH];
  logic [DEPTH_LOG2:0] r_wr_ptr;
  logic [DEPTH_LOG2:0] r_rd_ptr;
  logic                w_do_push;
  logic                w_do_pop;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                 (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);

  // A pop frees the slot a simultaneous push needs when full.
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= din;
  end

  assign dout = empty ? 8'h00 : r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/ps2_rx_frontend.sv
// PS/2 device-to-host receiver: synchroniser, falling-edge deframer with timeout, byte FIFO.
//  state     | meaning
//  RX_IDLE   | waiting for start bit (data low on a ps2_clk fall)
//  RX_SHIFT  | collecting 8 data bits, LSB first
//  RX_PARITY | next fall carries the odd-parity bit
//  RX_STOP   | next fall carries the stop bit; push or flag error
module ps2_rx_frontend
  import ps2_pkg::*;
#(
  parameter int DEPTH_LOG2  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_ONE  = 1;
  localparam logic [2:0]    LAST_BIT   = 3'(FRAME_DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;
  logic                   w_clk_s;
  logic                   w_data_s;
  logic                   w_fall;

  rx_state_t  r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_sr, w_sr_nxt;
  logic       r_par, w_par_nxt;
  logic [TW-1:0] r_timer;
  logic       w_timeout;
  logic       w_push;
  logic       w_err;
  logic       r_frame_err;
  logic       r_overflow;
  logic       w_empty;
  logic       w_full;
  logic       w_pop_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_sync  <= {SYNC_STAGES{PS2_IDLE_LEVEL}};
      r_data_sync <= {SYNC_STAGES{PS2_IDLE_LEVEL}};
      r_clk_prev  <= PS2_IDLE_LEVEL;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
      r_clk_prev  <= w_clk_s;
    end
  end

  assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];
  assign w_fall   = r_clk_prev & ~w_clk_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_sr    <= '0;
      r_par   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sr    <= w_sr_nxt;
      r_par   <= w_par_nxt;
    end
  end

  // Down-counter reloads on every fall; reaching zero mid-frame aborts it.
  always_ff @(posedge clk) begin
    if (rst)                                       r_timer <= '0;
    else if (w_fall)                               r_timer <= TIMER_LOAD;
    else if (r_state != RX_IDLE && r_timer != '0)  r_timer <= r_timer - TIMER_ONE;
  end

  assign w_timeout = (r_state != RX_IDLE) && (r_timer == '0) && !w_fall;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sr_nxt    = r_sr;
    w_par_nxt   = r_par;
    w_push      = 1'b0;
    w_err       = 1'b0;
    if (w_timeout) begin
      w_state_nxt = RX_IDLE;
      w_err       = 1'b1;
    end else if (w_fall) begin
      case (r_state)
        RX_IDLE: begin
          if (!w_data_s) begin
            w_state_nxt = RX_SHIFT;
            w_cnt_nxt   = '0;
          end
        end
        RX_SHIFT: begin
          w_sr_nxt  = {w_data_s, r_sr[7:1]};
          w_cnt_nxt = r_cnt + 3'd1;
          if (r_cnt == LAST_BIT) w_state_nxt = RX_PARITY;
        end
        RX_PARITY: begin
          w_par_nxt   = w_data_s;
          w_state_nxt = RX_STOP;
        end
        RX_STOP: begin
          if (w_data_s && (^{r_sr, r_par})) w_push = 1'b1;
          else                              w_err  = 1'b1;
          w_state_nxt = RX_IDLE;
        end
        default: w_state_nxt = RX_IDLE;
      endcase
    end
  end

  assign w_pop_req = ~nextdata_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_frame_err <= w_err;
      if (w_push && w_full && !w_pop_req) r_overflow <= 1'b1;
    end
  end

  byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (r_sr),
    .pop   (w_pop_req),
    .dout  (data),
    .empty (w_empty),
    .full  (w_full)
  );

  assign ready     = ~w_empty;
  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_rx_frontend.sv
// Self-checking bench for ps2_rx_frontend: frame table plus overflow/timeout/reset sequences.
module tb_ps2_rx_frontend;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  ps2_rx_frontend dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int err_cnt = 0;
  int err_wide = 0;
  logic fe_prev = 1'b0;
  logic [7:0] q_exp[$];
  logic exp_ovf = 1'b0;

  always @(negedge clk) begin
    if (frame_err) err_cnt++;
    if (frame_err && fe_prev) err_wide++;
    fe_prev = frame_err;
  end

  typedef struct {
    logic [7:0] b;
    bit         bad_par;
    bit         bad_stop;
    bit         exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input bit flip_par, input bit stop);
    logic par;
    par = (~^b) ^ flip_par;
    return {stop, par, b, 1'b0};
  endfunction

  // Bit i of 'bits' goes out on the i-th ps2_clk fall. Optionally pops exactly
  // in the cycle the stop-bit fall is detected (2 sync stages + edge flop).
  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit pop_at_stop);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = bits[i];
      repeat (4) @(negedge clk);
      ps2_clk = 1'b0;
      if (pop_at_stop && i == 10) begin
        @(negedge clk);
        @(negedge clk);
        nextdata_n = 1'b0;
        @(negedge clk);
        nextdata_n = 1'b1;
        repeat (5) @(negedge clk);
      end else begin
        repeat (8) @(negedge clk);
      end
      ps2_clk = 1'b1;
      repeat (4) @(negedge clk);
    end
    ps2_data = 1'b1;
  endtask

  task automatic model_push(input logic [7:0] b);
    if (q_exp.size() < 8) q_exp.push_back(b);
    else exp_ovf = 1'b1;
  endtask

  task automatic pop_check(input string name);
    logic [7:0] e;
    @(negedge clk);
    if (q_exp.size() == 0) begin
      check({name, "_empty_model"}, 32'(q_exp.size()), 32'd1);
    end else begin
      e = q_exp.pop_front();
      check({name, "_ready"}, 32'(ready), 32'd1);
      check({name, "_data"}, 32'(data), 32'(e));
      nextdata_n = 1'b0;
      @(negedge clk);
      nextdata_n = 1'b1;
    end
  endtask

  vec_t vecs[7];
  int e0;
  logic [7:0] head;

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h1C, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{8'h00, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 1'b1, 1'b0, 1'b1};

    repeat (4) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_data", 32'(data), 32'h00);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      e0 = err_cnt;
      send_bits(mk(vecs[i].b, vecs[i].bad_par, !vecs[i].bad_stop), 11, 1'b0);
      check($sformatf("vec%0d_err", i), 32'(err_cnt - e0), vecs[i].exp_err ? 32'd1 : 32'd0);
      if (!vecs[i].exp_err) begin
        model_push(vecs[i].b);
        pop_check($sformatf("vec%0d", i));
      end
      @(negedge clk);
      check($sformatf("vec%0d_ready_after", i), 32'(ready), 32'd0);
    end

    // Idle-level glitch: a fall with data high must not start a frame or flag.
    e0 = err_cnt;
    send_bits(11'h7FF, 1, 1'b0);
    check("glitch_err", 32'(err_cnt - e0), 32'd0);
    check("glitch_ready", 32'(ready), 32'd0);

    // Stall after 4 data bits past the timeout, then a clean frame.
    e0 = err_cnt;
    send_bits(mk(8'h3C, 1'b0, 1'b1), 5, 1'b0);
    repeat (5100) @(negedge clk);
    check("timeout_err", 32'(err_cnt - e0), 32'd1);
    check("timeout_ready", 32'(ready), 32'd0);
    e0 = err_cnt;
    send_bits(mk(8'hF0, 1'b0, 1'b1), 11, 1'b0);
    model_push(8'hF0);
    check("after_timeout_err", 32'(err_cnt - e0), 32'd0);
    pop_check("after_timeout");

    // Nine frames with no pops: ninth is dropped.
    for (int k = 1; k <= 9; k++) begin
      send_bits(mk(8'(k), 1'b0, 1'b1), 11, 1'b0);
      model_push(8'(k));
    end
    @(negedge clk);
    check("ovf_set", 32'(overflow), 32'(exp_ovf));
    for (int k = 0; k < 8; k++) pop_check($sformatf("ovf_pop%0d", k));
    @(negedge clk);
    check("ovf_drained_ready", 32'(ready), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Reset mid-frame with bytes queued.
    for (int k = 0; k < 3; k++) begin
      send_bits(mk(8'h11 * 8'(k + 1), 1'b0, 1'b1), 11, 1'b0);
      model_push(8'h11 * 8'(k + 1));
    end
    e0 = err_cnt;
    send_bits(mk(8'h77, 1'b0, 1'b1), 5, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q_exp.delete();
    exp_ovf = 1'b0;
    @(negedge clk);
    check("midrst_ready", 32'(ready), 32'd0);
    check("midrst_data", 32'(data), 32'h00);
    check("midrst_overflow", 32'(overflow), 32'(exp_ovf));
    send_bits(mk(8'h5A, 1'b0, 1'b1), 11, 1'b0);
    model_push(8'h5A);
    check("midrst_err", 32'(err_cnt - e0), 32'd0);
    pop_check("midrst_5a");

    // Full FIFO, pop in the same cycle the ninth byte pushes.
    for (int k = 1; k <= 8; k++) begin
      send_bits(mk(8'(k), 1'b0, 1'b1), 11, 1'b0);
      model_push(8'(k));
    end
    @(negedge clk);
    head = q_exp.pop_front();
    check("full_head", 32'(data), 32'(head));
    send_bits(mk(8'h09, 1'b0, 1'b1), 11, 1'b1);
    q_exp.push_back(8'h09);
    check("simul_overflow", 32'(overflow), 32'd0);
    for (int k = 0; k < 8; k++) pop_check($sformatf("simul_pop%0d", k));
    @(negedge clk);
    check("simul_drained_ready", 32'(ready), 32'd0);
    check("simul_drained_data", 32'(data), 32'h00);

    // Pop request while empty is ignored.
    nextdata_n = 1'b0;
    @(negedge clk);
    nextdata_n = 1'b1;
    send_bits(mk(8'hC3, 1'b0, 1'b1), 11, 1'b0);
    model_push(8'hC3);
    pop_check("empty_pop_ignored");

    check("frame_err_width", 32'(err_wide), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
